// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-2 Booth multiplier.
// Operand extension happens at accept time so one signed datapath covers both modes.
package booth_pkg;

  localparam int unsigned MAX_W   = 32;
  localparam int unsigned MAX_EXT = MAX_W + 1;

  typedef logic [MAX_W-1:0] word_t;
  typedef logic [MAX_EXT:0] ext_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Booth control encodings, indexed by {mq[0], q_m1}
  localparam logic [1:0] BOOTH_NOP_LO = 2'b00;
  localparam logic [1:0] BOOTH_ADD    = 2'b01;
  localparam logic [1:0] BOOTH_SUB    = 2'b10;
  localparam logic [1:0] BOOTH_NOP_HI = 2'b11;

  // Extends the low `width` bits of value; callers truncate the result to EXT or EXT+1 bits.
  function automatic ext_t booth_ext(input word_t value, input int unsigned width,
                                     input logic is_signed);
    ext_t r;
    logic fill;
    fill = is_signed & value[5'(width - 1)];
    r    = ext_t'(value);
    for (int unsigned i = 0; i <= MAX_EXT; i++) begin
      if (i >= width) r[6'(i)] = fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_mul_seq_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into acc,
// then an arithmetic right shift of {acc, mq, q_m1}.
import booth_pkg::*;

module booth_mul_seq_step #(
  parameter int unsigned EXT = 9
) (
  input  logic [EXT:0]   i_acc,
  input  logic [EXT-1:0] i_mq,
  input  logic           i_q_m1,
  input  logic [EXT:0]   i_m,
  output logic [EXT:0]   o_acc,
  output logic [EXT-1:0] o_mq,
  output logic           o_q_m1
);

  logic [EXT:0] w_sum;

  always_comb begin
    w_sum = i_acc;
    case ({i_mq[0], i_q_m1})
      BOOTH_SUB: w_sum = i_acc - i_m;
      BOOTH_ADD: w_sum = i_acc + i_m;
      default:   w_sum = i_acc;
    endcase
    {o_acc, o_mq, o_q_m1} = {w_sum[EXT], w_sum, i_mq};
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-2 Booth multiplier with valid/ready handshakes on both sides.
// One operation in flight; the product is held in DONE until the consumer takes it.
import booth_pkg::*;

module booth_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned EXT = WIDTH + 1;
  localparam int unsigned CW  = $clog2(EXT + 1);

  state_e               r_state;
  logic [EXT:0]         r_acc;
  logic [EXT:0]         r_m;
  logic [EXT-1:0]       r_mq;
  logic                 r_q_m1;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_in_ready;
  logic                 r_out_valid;

  logic [EXT:0]         w_m_ext;
  logic [EXT-1:0]       w_mq_ext;
  logic [EXT:0]         w_acc_n;
  logic [EXT-1:0]       w_mq_n;
  logic                 w_q_m1_n;
  logic [2*WIDTH-1:0]   w_prod;

  // Mode is applied here at accept; afterwards only the extended operands matter.
  assign w_m_ext  = (EXT+1)'(booth_ext(word_t'(multiplicand), WIDTH, is_signed));
  assign w_mq_ext = EXT'(booth_ext(word_t'(multiplier), WIDTH, is_signed));
  assign w_prod   = (2*WIDTH)'({w_acc_n, w_mq_n});

  booth_mul_seq_step #(
    .EXT(EXT)
  ) u_step (
    .i_acc (r_acc),
    .i_mq  (r_mq),
    .i_q_m1(r_q_m1),
    .i_m   (r_m),
    .o_acc (w_acc_n),
    .o_mq  (w_mq_n),
    .o_q_m1(w_q_m1_n)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_m         <= '0;
      r_mq        <= '0;
      r_q_m1      <= 1'b0;
      r_cnt       <= '0;
      r_product   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc      <= '0;
            r_mq       <= w_mq_ext;
            r_q_m1     <= 1'b0;
            r_m        <= w_m_ext;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_acc  <= w_acc_n;
          r_mq   <= w_mq_n;
          r_q_m1 <= w_q_m1_n;
          r_cnt  <= r_cnt + 1'b1;
          // Last step: capture the post-step value so out_valid rises EXT edges after accept
          if (r_cnt == CW'(EXT - 1)) begin
            r_product   <= w_prod;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: directed WIDTH=8 cases plus randomized WIDTH=4/16 sweeps
// against an integer-arithmetic reference model.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        iv;
  logic        ordy;
  logic [15:0] a;
  logic [15:0] b;
  logic        s;
  int unsigned cur_w;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic        iv4, iv8, iv16, or4, or8, or16;
  logic        ir4, ir8, ir16, ov4, ov8, ov16;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;
  logic        cur_ir, cur_ov;
  logic [31:0] cur_p;

  always #5 clk = ~clk;

  assign iv4  = iv   && (cur_w == 4);
  assign iv8  = iv   && (cur_w == 8);
  assign iv16 = iv   && (cur_w == 16);
  assign or4  = ordy && (cur_w == 4);
  assign or8  = ordy && (cur_w == 8);
  assign or16 = ordy && (cur_w == 16);

  booth_mul_seq #(.WIDTH(4)) u4 (
    .clk(clk), .n_rst(n_rst), .in_valid(iv4), .in_ready(ir4),
    .multiplicand(a[3:0]), .multiplier(b[3:0]), .is_signed(s),
    .out_valid(ov4), .out_ready(or4), .product(p4));

  booth_mul_seq #(.WIDTH(8)) u8 (
    .clk(clk), .n_rst(n_rst), .in_valid(iv8), .in_ready(ir8),
    .multiplicand(a[7:0]), .multiplier(b[7:0]), .is_signed(s),
    .out_valid(ov8), .out_ready(or8), .product(p8));

  booth_mul_seq #(.WIDTH(16)) u16 (
    .clk(clk), .n_rst(n_rst), .in_valid(iv16), .in_ready(ir16),
    .multiplicand(a), .multiplier(b), .is_signed(s),
    .out_valid(ov16), .out_ready(or16), .product(p16));

  always_comb begin
    cur_ir = ir8;
    cur_ov = ov8;
    cur_p  = 32'(p8);
    case (cur_w)
      4:  begin cur_ir = ir4;  cur_ov = ov4;  cur_p = 32'(p4); end
      16: begin cur_ir = ir16; cur_ov = ov16; cur_p = p16;     end
      default: ;
    endcase
  end

  // Interpret operands as integers, multiply, keep 2*w bits.
  function automatic logic [31:0] ref_mul(input logic [15:0] ta, input logic [15:0] tb,
                                          input logic ts, input int unsigned w);
    longint mk, va, vb, p;
    mk = (longint'(1) << w) - 1;
    va = longint'(ta) & mk;
    vb = longint'(tb) & mk;
    if (ts && va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
    if (ts && vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
    p = va * vb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input int unsigned w, input logic [15:0] ta,
                        input logic [15:0] tb, input logic ts, input logic [31:0] exp,
                        input int unsigned pre_gap, input int unsigned hold, input bit poke);
    int unsigned lat;
    cur_w = w;
    repeat (pre_gap) @(negedge clk);
    a = ta; b = tb; s = ts; iv = 1'b1; ordy = 1'b0;
    check({tag, ":in_ready"}, 32'(cur_ir), 32'd1);
    @(negedge clk);
    iv = 1'b0;
    a = 16'($urandom); b = 16'($urandom); s = ~ts;
    lat = 0;
    while (!cur_ov && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'(w + 1));
    check({tag, ":product"}, cur_p, exp);
    for (int unsigned i = 0; i < hold; i++) begin
      if (poke) begin
        a = 16'h0055; b = 16'h0033; iv = 1'b1;
        check({tag, ":busy_in_ready"}, 32'(cur_ir), 32'd0);
      end
      @(negedge clk);
      check({tag, ":held_valid"}, 32'(cur_ov), 32'd1);
      check({tag, ":held_product"}, cur_p, exp);
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check({tag, ":valid_drop"}, 32'(cur_ov), 32'd0);
    check({tag, ":ready_back"}, 32'(cur_ir), 32'd1);
    check({tag, ":product_kept"}, cur_p, exp);
  endtask

  initial begin
    n_rst = 1'b0; iv = 1'b0; ordy = 1'b0; a = '0; b = '0; s = 1'b0; cur_w = 8;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    for (int unsigned k = 0; k < 3; k++) begin
      cur_w = (k == 0) ? 4 : (k == 1) ? 8 : 16;
      #0;
      check("reset:in_ready", 32'(cur_ir), 32'd1);
      check("reset:out_valid", 32'(cur_ov), 32'd0);
      check("reset:product", cur_p, 32'd0);
    end

    run_op("umax", 8, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, 0, 0, 0);

    // Reset asserted for two edges in the middle of CALC
    cur_w = 8;
    a = 16'h0077; b = 16'h0011; s = 1'b0; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("midreset:out_valid", 32'(cur_ov), 32'd0);
    check("midreset:in_ready", 32'(cur_ir), 32'd1);
    check("midreset:product", cur_p, 32'd0);
    repeat (12) @(negedge clk);
    check("midreset:no_late_valid", 32'(cur_ov), 32'd0);

    run_op("s_m1x1",   8, 16'h00FF, 16'h0001, 1'b1, 32'h0000FFFF, 0, 0, 0);
    run_op("s_minmin", 8, 16'h0080, 16'h0080, 1'b1, 32'h00004000, 1, 0, 0);
    run_op("s_minmax", 8, 16'h0080, 16'h007F, 1'b1, 32'h0000C080, 0, 1, 0);
    run_op("backpress", 8, 16'h000C, 16'h000D, 1'b0, 32'h0000009C, 0, 5, 1);
    run_op("mode_u",   8, 16'h00F0, 16'h0002, 1'b0, 32'h000001E0, 0, 0, 0);
    run_op("mode_s",   8, 16'h00F0, 16'h0002, 1'b1, 32'h0000FFE0, 0, 0, 0);
    run_op("zero",     8, 16'h0000, 16'h00AB, 1'b1, 32'h00000000, 0, 0, 0);
    run_op("s_min16",  16, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, 0, 0);

    for (int unsigned k = 0; k < 2; k++) begin
      int unsigned w;
      w = (k == 0) ? 4 : 16;
      for (int unsigned n = 0; n < 200; n++) begin
        logic [15:0] ra, rb;
        logic        rs;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom);
        if (n < 4) begin
          ra = (w == 4) ? 16'h0008 : 16'h8000;
          rb = (n[0]) ? ra : 16'hFFFF;
        end
        run_op((w == 4) ? "sweep4" : "sweep16", w, ra, rb, rs, ref_mul(ra, rb, rs, w),
               $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
